// File: rtl/cache_arbiter_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package  : arbiter_types                                                 |
// | Purpose  : Shared types and constants for the I/D-cache memory arbiter.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package arbiter_types;

   // Arbiter sequencing states, explicitly 2 bits wide
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_I  = 2'd1,
      BUSY_D  = 2'd2,
      RECOVER = 2'd3
   } arb_state_t;

   // Identity of the requester that was served most recently
   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } arb_src_t;

   // Address bits below this index select bytes within a line
   localparam int LINE_OFFSET_BITS = 5;

endpackage : arbiter_types

`default_nettype wire

// File: rtl/cache_arbiter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : cache_arbiter                                                 |
// | Purpose  : Shares one cacheline-wide memory port between the I-cache and |
// |            D-cache miss paths, one transfer at a time, round-robin on    |
// |            simultaneous misses, with a latched command per transaction.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module cache_arbiter
   import arbiter_types::*;
#(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // I-cache miss interface
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   // D-cache miss interface
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   // Shared memory port
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   // Contention statistics
   output logic [31:0]       conflict_count
);

   // Clears the in-line byte offset so memory always sees aligned addresses
   localparam logic [ADDR_W-1:0] ADDR_MASK =
      ~(ADDR_W'((1 << LINE_OFFSET_BITS) - 1));

   arb_state_t state;
   arb_state_t next_state;
   arb_src_t   last_grant;
   logic       op_write;

   logic       d_req;
   logic       both_req;
   logic       grant_d;
   logic       grant_i;

   // A D-side write wins over a simultaneous D-side read; the read is dropped
   assign d_req    = d_read | d_write;
   assign both_req = i_read & d_req;
   // On contention the side that was not served last goes first
   assign grant_d  = d_req & (~i_read | (last_grant == SRC_I));
   assign grant_i  = i_read & ~grant_d;

   // Line data is passed straight through; only the resp pulses qualify it
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state: grant from IDLE, wait for mem_resp, then one RECOVER cycle
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (grant_d)      next_state = BUSY_D;
            else if (grant_i) next_state = BUSY_I;
         end
         BUSY_I:  if (mem_resp) next_state = RECOVER;
         BUSY_D:  if (mem_resp) next_state = RECOVER;
         RECOVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs: level memory commands while busy, resp pulses on mem_resp
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      unique case (state)
         BUSY_I: begin
            mem_read = 1'b1;
            i_resp   = mem_resp;
         end
         BUSY_D: begin
            mem_read  = ~op_write;
            mem_write = op_write;
            d_resp    = mem_resp;
         end
         default: ;
      endcase
   end

   // Command latch: requester inputs are only looked at while IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         op_write  <= 1'b0;
      end else if (state == IDLE) begin
         if (grant_d) begin
            mem_addr  <= d_addr & ADDR_MASK;
            mem_wdata <= d_wdata;
            op_write  <= d_write;
         end else if (grant_i) begin
            mem_addr  <= i_addr & ADDR_MASK;
         end
      end
   end

   // Round-robin history, updated when a transaction completes
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= SRC_I;
      end else if (mem_resp) begin
         if (state == BUSY_I)      last_grant <= SRC_I;
         else if (state == BUSY_D) last_grant <= SRC_D;
      end
   end

   // Saturating count of IDLE cycles with both caches requesting
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_count <= '0;
      end else if ((state == IDLE) && both_req && (conflict_count != '1)) begin
         conflict_count <= conflict_count + 32'd1;
      end
   end

endmodule : cache_arbiter

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module   : tb_cache_arbiter                                              |
// | Purpose  : Self-checking bench for cache_arbiter against a transaction-  |
// |            level reference model.                                        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int OWN_NONE = 0;
   localparam int OWN_I    = 1;
   localparam int OWN_D    = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;
   logic [31:0]       conflict_count;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: who owns the port, what was latched, round-robin memory
   int                owner;
   bit                cooling;
   bit                last_was_d;
   bit                m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   logic [31:0]       m_conf;

   cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .conflict_count(conflict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                        input logic [LINE_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner      = OWN_NONE;
      cooling    = 1'b0;
      last_was_d = 1'b0;
      m_wr       = 1'b0;
      m_addr     = '0;
      m_wdata    = '0;
      m_conf     = '0;
   endtask

   // Check all outputs mid-cycle, then advance the model on the clock edge
   task automatic cycle();
      bit iq, dq;
      @(negedge clk);
      check("mem_read",  LINE_W'(mem_read),
            LINE_W'((owner == OWN_I) || (owner == OWN_D && !m_wr)));
      check("mem_write", LINE_W'(mem_write), LINE_W'(owner == OWN_D && m_wr));
      check("mem_addr",  LINE_W'(mem_addr),  LINE_W'(m_addr));
      check("mem_wdata", mem_wdata, m_wdata);
      check("i_resp", LINE_W'(i_resp), LINE_W'(owner == OWN_I && mem_resp));
      check("d_resp", LINE_W'(d_resp), LINE_W'(owner == OWN_D && mem_resp));
      check("i_rdata", i_rdata, mem_rdata);
      check("d_rdata", d_rdata, mem_rdata);
      check("conflict_count", LINE_W'(conflict_count), LINE_W'(m_conf));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (cooling) begin
         cooling = 1'b0;
      end else if (owner != OWN_NONE) begin
         if (mem_resp) begin
            last_was_d = (owner == OWN_D);
            owner      = OWN_NONE;
            cooling    = 1'b1;
         end
      end else begin
         iq = i_read;
         dq = d_read | d_write;
         if (iq && dq) begin
            if (m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
            owner = last_was_d ? OWN_I : OWN_D;
         end else if (dq) begin
            owner = OWN_D;
         end else if (iq) begin
            owner = OWN_I;
         end
         if (owner == OWN_D) begin
            m_addr  = d_addr & ~32'h1F;
            m_wdata = d_wdata;
            m_wr    = d_write;
         end else if (owner == OWN_I) begin
            m_addr = i_addr & ~32'h1F;
         end
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [LINE_W-1:0] rnd;
      rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
      model_reset();
      @(posedge clk); #1;
      run(2);
      rst = 1'b0;

      // I-only read with address churn while busy
      i_read = 1; i_addr = 32'h0000_1234;
      run(1);
      check("i_grant_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_1220));
      i_addr = 32'hFFFF_FFFF;
      run(3);
      mem_rdata = {32{8'hA5}}; mem_resp = 1;
      run(1);
      i_read = 0; mem_resp = 0;
      run(2);
      check("i_churn_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_1220));

      // D writeback with d_read also high: issued as a write
      d_write = 1; d_read = 1; d_addr = 32'h8000_0040; d_wdata = {8{32'hDEAD_BEEF}};
      run(1);
      check("d_wb_write", LINE_W'(mem_write), LINE_W'(1'b1));
      run(2);
      mem_resp = 1; run(1);
      d_write = 0; d_read = 0; mem_resp = 0;
      run(2);

      // Simultaneous miss after reset: D first, then pending I without a count
      do_reset();
      i_read = 1; i_addr = 32'h0000_2000; d_read = 1; d_addr = 32'h0000_3000;
      run(1);
      check("first_conflict_d", LINE_W'(mem_addr), LINE_W'(32'h0000_3000));
      run(1);
      mem_resp = 1; run(1);
      d_read = 0; mem_resp = 0;
      run(2);
      mem_resp = 1; run(1);
      i_read = 0; mem_resp = 0;
      run(2);
      check("conflict_once", LINE_W'(conflict_count), LINE_W'(32'd1));

      // Sustained contention: D writes alternate with I reads
      do_reset();
      i_read = 1; d_write = 1; d_addr = 32'h0000_4000;
      for (int t = 0; t < 4; t++) begin
         run(1);
         check("rr_order", LINE_W'(mem_write), LINE_W'((t % 2) == 0));
         run(1);
         mem_resp = 1;
         if (t == 3) begin i_read = 0; d_write = 0; end
         run(1);
         mem_resp = 0;
         run(1);
      end
      check("conflict_four", LINE_W'(conflict_count), LINE_W'(32'd4));

      // Reset during BUSY_D, then a late mem_resp is ignored
      d_read = 1; d_addr = 32'h0000_5000;
      run(2);
      rst = 1; run(1);
      rst = 0; d_read = 0; mem_resp = 1;
      run(1);
      mem_resp = 0;
      run(2);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 99) == 0);
         i_read  = ($urandom_range(0, 2) != 0);
         d_read  = ($urandom_range(0, 2) == 0);
         d_write = ($urandom_range(0, 3) == 0);
         i_addr  = $urandom;
         d_addr  = $urandom;
         for (int w = 0; w < LINE_W / 32; w++) rnd[w*32 +: 32] = $urandom;
         d_wdata = rnd;
         for (int w = 0; w < LINE_W / 32; w++) rnd[w*32 +: 32] = $urandom;
         mem_rdata = rnd;
         mem_resp  = ($urandom_range(0, 9) < 3);
         run(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_cache_arbiter

`default_nettype wire

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single cacheline-wide memory port (L2 / physical memory) between the I-cache and D-cache miss interfaces of the pipelined RV32I core. Sequences one line transfer at a time through a small FSM. Grants round-robin when both caches miss together. Latches the winner's command so the memory port sees stable signals for the whole transaction.

## Interface
- `LINE_W`, default 256: cacheline width in bits.
- `ADDR_W`, default 32: physical address width; addresses are line-aligned (low 5 bits ignored, driven as zero to memory).
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `i_read` in 1: I-cache line read request, held until `i_resp`.
- `i_addr` in ADDR_W: I-cache line address.
- `i_rdata` out LINE_W: line returned to I-cache.
- `i_resp` out 1: one-cycle completion pulse to I-cache.
- `d_read` in 1: D-cache line read request.
- `d_write` in 1: D-cache writeback request.
- `d_addr` in ADDR_W: D-cache line address.
- `d_wdata` in LINE_W: writeback line.
- `d_rdata` out LINE_W: line returned to D-cache.
- `d_resp` out 1: one-cycle completion pulse to D-cache.
- `mem_read` out 1: memory read command.
- `mem_write` out 1: memory write command.
- `mem_addr` out ADDR_W: latched line address, low 5 bits zero.
- `mem_wdata` out LINE_W: latched writeback data.
- `mem_rdata` in LINE_W: memory read data, valid with `mem_resp`.
- `mem_resp` in 1: memory completion pulse.
- `conflict_count` out 32: saturating count of IDLE cycles in which both caches requested.

## Operation
- States: `IDLE`, `BUSY_I`, `BUSY_D`, `RECOVER`.
- IDLE:
  - If only I requests, latch `i_addr` and go to BUSY_I.
  - If only D requests, latch `d_addr`/`d_wdata` and the op (write if `d_write`, else read), then go to BUSY_D.
  - If both request, grant the side not granted last and increment `conflict_count` (saturates at 0xFFFF_FFFF).
  - `last_grant` resets to I, so the first conflict goes to D.
- `d_read` and `d_write` both high: treated as a write, and the read is ignored.
- BUSY_I: `mem_read`=1. On `mem_resp`:
  - `i_resp`=1 combinationally that cycle, with `i_rdata`=`mem_rdata`.
  - `last_grant`←I; next state RECOVER.
- BUSY_D: `mem_read` or `mem_write` per the latched op. On `mem_resp`:
  - `d_resp`=1 combinationally; `d_rdata`=`mem_rdata` (don't-care for a write).
  - `last_grant`←D; next state RECOVER.
- RECOVER: no memory command and no grant. Always goes to IDLE next cycle. This lets the requester drop its request, so a stale request is never re-granted.
- `mem_resp` in IDLE or RECOVER is ignored.
- `i_rdata`/`d_rdata` mirror `mem_rdata` at all times; only the resp pulses are gated.
- Requester inputs are sampled only in IDLE; later changes do not affect the in-flight transaction.

## Timing
- Reset values:
  - state IDLE, `last_grant`=I.
  - All `*_resp`, `mem_read`, `mem_write` = 0.
  - `mem_addr`/`mem_wdata` registers = 0.
  - `conflict_count`=0.
- Reset mid-transaction: returns to IDLE next cycle with the command dropped. The abandoned `mem_resp` is ignored.
- Grant latency: request seen in IDLE at cycle N → memory command asserted at cycle N+1.
- Response latency: `mem_resp` at cycle M → `*_resp` at cycle M (zero added latency). RECOVER is cycle M+1, and the earliest next grant decision is at M+2.
- Minimum occupancy per transaction: 3 cycles plus memory latency.
- Memory commands are level signals, held constant from grant until the `mem_resp` cycle inclusive.

## Structure
- Shared package `arbiter_types`:
  - `arb_state_t` enum (IDLE, BUSY_I, BUSY_D, RECOVER).
  - `arb_src_t` enum (SRC_I, SRC_D).
  - Constant `LINE_OFFSET_BITS`=5.
- Single module; no sub-module warranted. The counter is inline.

## Test plan
- I-only: `i_read`=1, `i_addr`=0x0000_1234, memory resp after 4 cycles with data 0xA5… → `mem_read` from N+1 with `mem_addr`=0x0000_1220. `i_resp` pulses once with data 0xA5…; `d_resp` stays 0.
- D writeback: `d_write`=1, `d_addr`=0x8000_0040, `d_wdata`=0xDEAD… → `mem_write`=1 with latched data, one `d_resp`, RECOVER, then IDLE.
- Simultaneous miss after reset: both request → D granted first and `conflict_count`=1. I is still pending, so I is granted at the next IDLE with no count increment.
- Sustained contention, both held for 4 transactions → grants alternate D,I,D,I. No request is re-served from the RECOVER cycle, and each resp pulses exactly once per transaction.
- Reset during BUSY_D, then a late `mem_resp` → IDLE with all commands 0, no `d_resp`, and the late resp ignored.
- Input churn: change `i_addr` during BUSY_I → `mem_addr` unchanged. `d_read`&`d_write` both high → write issued.
